vector_mem_seq: RTL

- Multi-cycle sequencer for the vector load/store instructions (VLD, VST).
- Takes the effective base address (scalar register plus sign-extended 6-bit offset, summed upstream from the picked operands) and moves one 256-bit vector as 16 consecutive 16-bit element transfers over the single-ported data memory.
- Holds the pipeline via busy, then pulses done. For VLD it also presents the assembled vector to the vector register file write port.

---
 rtl/cvp14_pkg.sv | 34 +++
 rtl/vector_mem_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cvp14_pkg.sv
// cvp14_pkg -- definitions shared by the cvp14 vector core.
//
// Contents:
//   - datapath geometry (elements per vector, element/address widths)
//   - 4-bit instruction opcodes shared by the decoder, the operand picker
//     and the vector memory sequencer
//   - state encoding of the vector memory sequencer (vector_mem_seq)
package cvp14_pkg;

  localparam int VEC_ELEMS = 16;
  localparam int ELEM_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int VEC_W     = VEC_ELEMS * ELEM_W;

  // Instruction opcodes.
  localparam logic [3:0] OP_VADD = 4'h0;
  localparam logic [3:0] OP_VDOT = 4'h1;
  localparam logic [3:0] OP_SMUL = 4'h2;
  localparam logic [3:0] OP_SST  = 4'h3;
  localparam logic [3:0] OP_VLD  = 4'h4;
  localparam logic [3:0] OP_VST  = 4'h5;
  localparam logic [3:0] OP_SLL  = 4'h6;
  localparam logic [3:0] OP_SLH  = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;
  localparam logic [3:0] OP_NOP  = 4'hF;

  // Vector memory sequencer states.
  typedef enum logic [1:0] {
    VMEM_IDLE = 2'd0,
    VMEM_XFER = 2'd1,
    VMEM_DONE = 2'd2
  } vmem_state_e;

endpackage

// File: rtl/vector_mem_seq.sv
// vector_mem_seq -- multi-cycle sequencer for VLD / VST.
//
// Moves one vector of ELEMS elements between the vector datapath and the
// single-ported data memory, one element per acknowledged access.
//
// Optional build macro: VMEM_STRIDE_EN
//   defined   : adds a signed 8-bit 'stride' input captured with start;
//               element i lives at base + i*stride (mod 2^AW).
//   undefined : element i lives at base + i (mod 2^AW).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        transfer request, honoured only while idle
//   is_store     1 = VST, 0 = VLD (captured with start)
//   base_addr    address of element 0 (captured with start)
//   vec_wdata    store vector, element i at [i*DW +: DW] (captured with start)
//   stride       (VMEM_STRIDE_EN only) signed element stride
//   mem_req/we/addr/wdata  registered memory request
//   mem_ack      access accepted; read data valid in the same cycle
//   mem_rdata    read data
//   busy         pipeline stall, high from the cycle after start until done
//   done         one-cycle completion pulse
//   vec_rdata    assembled load vector, stable from done to the next start
//   vec_we       register-file write strobe (done of a load)
//
// Handshake: a request (mem_req=1 with mem_we/mem_addr/mem_wdata) is held
// unchanged until the cycle in which mem_ack=1; that cycle completes the
// access and the next request (if any) appears in the following cycle.
module vector_mem_seq
  import cvp14_pkg::*;
#(
  parameter int ELEMS = VEC_ELEMS,
  parameter int DW    = ELEM_W,
  parameter int AW    = ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                is_store,
  input  logic [AW-1:0]       base_addr,
  input  logic [ELEMS*DW-1:0] vec_wdata,
`ifdef VMEM_STRIDE_EN
  input  logic [7:0]          stride,
`endif
  output logic                mem_req,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic                mem_ack,
  input  logic [DW-1:0]       mem_rdata,
  output logic                busy,
  output logic                done,
  output logic [ELEMS*DW-1:0] vec_rdata,
  output logic                vec_we
);

  localparam int            IW   = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [IW-1:0] LAST = IW'(ELEMS - 1);

  vmem_state_e         state;
  logic [IW-1:0]       idx;
  logic                store_q;
  // Store elements not yet presented; element idx+1 sits in the low DW bits.
  logic [ELEMS*DW-1:0] wdata_q;
  logic [AW-1:0]       addr_step;

`ifdef VMEM_STRIDE_EN
  logic [7:0] stride_q;
  assign addr_step = {{(AW-8){stride_q[7]}}, stride_q};
`else
  assign addr_step = AW'(1);
`endif

  // The address of element i is base + i*step; stepping the registered
  // address by one step per ack gives the same result with a single adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= VMEM_IDLE;
      idx       <= '0;
      store_q   <= 1'b0;
      wdata_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      vec_we    <= 1'b0;
      vec_rdata <= '0;
`ifdef VMEM_STRIDE_EN
      stride_q  <= '0;
`endif
    end else begin
      case (state)
        VMEM_IDLE: begin
          if (start) begin
            state     <= VMEM_XFER;
            idx       <= '0;
            store_q   <= is_store;
            wdata_q   <= vec_wdata >> DW;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= base_addr;
            mem_wdata <= vec_wdata[DW-1:0];
            busy      <= 1'b1;
`ifdef VMEM_STRIDE_EN
            stride_q  <= stride;
`endif
          end
        end

        VMEM_XFER: begin
          if (mem_ack) begin
            if (!store_q) begin
              vec_rdata[int'(idx)*DW +: DW] <= mem_rdata;
            end
            if (idx == LAST) begin
              state   <= VMEM_DONE;
              mem_req <= 1'b0;
              mem_we  <= 1'b0;
              done    <= 1'b1;
              vec_we  <= ~store_q;
            end else begin
              idx       <= idx + 1'b1;
              mem_addr  <= mem_addr + addr_step;
              mem_wdata <= wdata_q[DW-1:0];
              wdata_q   <= wdata_q >> DW;
            end
          end
        end

        VMEM_DONE: begin
          state  <= VMEM_IDLE;
          done   <= 1'b0;
          vec_we <= 1'b0;
          busy   <= 1'b0;
        end

        default: begin
          state <= VMEM_IDLE;
        end
      endcase
    end
  end

endmodule
